inst_queue: RTL and testbench
=============================

Name: inst_queue

Overview:
- Dual-push / dual-pop circular instruction buffer between fetch and the ID1 decode slots.
- Fetch writes 0-2 instructions per cycle.
- Issue logic removes 0-2 per cycle from the head.
- The two head entries drive the id1 slot inputs (valid/pc/inst) of the ID1->ID2 pipeline registers.
- Decouples the fetch rate from issue and stall, and is emptied on a branch or exception flush.

Parameters:
DEPTH, 16, number of entries; must be a power of 2, minimum 4
PTR_W, $clog2(DEPTH), pointer width (derived, not overridden)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush  in  1  branch/misfetch flush; empties queue
exception_flush  in  1  exception flush; empties queue
push0  in  1  fetch slot 0 valid
push1  in  1  fetch slot 1 valid (legal only with push0)
push0_pc  in  32  slot 0 PC
push0_inst  in  32  slot 0 instruction
push1_pc  in  32  slot 1 PC
push1_inst  in  32  slot 1 instruction
pop_cnt  in  2  entries consumed this cycle (0,1,2; 3 illegal)
full  out  1  fewer than 2 free entries; fetch must not push
empty  out  1  count == 0
head0_valid  out  1  entry at rd_ptr present
head0_pc  out  32  PC at rd_ptr
head0_inst  out  32  instruction at rd_ptr
head1_valid  out  1  entry at rd_ptr+1 present
head1_pc  out  32  PC at rd_ptr+1
head1_inst  out  32  instruction at rd_ptr+1
count  out  PTR_W+1  current occupancy

Behaviour:
State:
- wr_ptr and rd_ptr, each PTR_W bits, wrapping modulo DEPTH.
- cnt, PTR_W+1 bits, range 0..DEPTH.
- Storage is DEPTH x {pc, inst}. Storage is not reset.

Reset (rst=1 at posedge):
- wr_ptr=0, rd_ptr=0, cnt=0.
- Hence empty=1, full=0, head*_valid=0, head*_pc/inst=0.

Flush:
- flush | exception_flush at a posedge: wr_ptr=rd_ptr=cnt=0.
- Flush has priority over push and pop in the same cycle; both are discarded.
- rst has priority over everything.

Push, accepted at a posedge when !full and no flush:
- npush = push0 + push1.
- mem[wr_ptr] <= slot0. If push1, mem[wr_ptr+1] <= slot1.
- wr_ptr += npush.
- push1 without push0 is illegal; it is ignored (npush=0) and flagged by a bench assertion.

Push while full: dropped entirely. Pointers and storage are unchanged. This is a bench assertion error.

Pop:
- npop = min(pop_cnt, cnt), evaluated on the registered cnt. Over-pop saturates and never underflows.
- rd_ptr += npop.

Simultaneous push and pop:
- cnt_next = cnt - npop + npush.
- full is computed from the registered cnt only. Slots freed by a same-cycle pop do not enable a push.

Outputs:
- Combinational from registered state; zero-cycle read latency.
- head0_valid = cnt>=1; head1_valid = cnt>=2.
- head*_pc and head*_inst read mem[rd_ptr] and mem[rd_ptr+1] (wrapping), masked to 0 when the corresponding valid=0.
- full = cnt > DEPTH-2; empty = cnt==0.
- Pushed data is visible at the head the cycle after the push edge. There is no bypass from push to head.

Wrap-around: pointers wrap silently. A 2-push at wr_ptr=DEPTH-1 writes mem[DEPTH-1] and mem[0].

Ordering: program order is preserved. head0 is always older than head1.

Decomposition:
- Shared package (core-wide constants):
  - INST_W=32, PC_W=32.
  - Reset/flush value 32'h0 for pc and inst.
  - Issue-width constant ISSUE_W=2.
- One natural sub-module, iq_ram:
  - DEPTH x 64 storage with two write ports (addr, addr+1) and two asynchronous read ports.
  - Keeps pointer/count control in inst_queue separate from storage.

Test Plan:
1. Reset, then push0+push1 (pc 0xBFC00000/0xBFC00004, inst 0x24010001/0x24020002), pop_cnt=0 -> next cycle count=2, head0_pc=0xBFC00000, head1_inst=0x24020002, both valid, empty=0.
2. Fill to 15 entries with DEPTH=16 -> full=1. Push0+push1 while full -> count stays 15 and head unchanged. pop_cnt=2 -> count=13, full=0.
3. Wrap: drive wr_ptr=15 and rd_ptr=15 via 15 push/pop pairs, then dual-push A,B -> mem[15]=A, mem[0]=B. head0=A, head1=B in order.
4. cnt=1, pop_cnt=2 with simultaneous dual push -> npop=1, count=2. Heads are the two new instructions; no underflow.
5. cnt=6, flush=1 with push0+push1 and pop_cnt=1 -> next cycle count=0, both valid=0, head*_pc=0. Repeat with exception_flush alone, same result.
6. rst asserted with cnt=9 and a push/pop in flight -> next cycle count=0, empty=1, full=0, all head outputs 0. A push the following cycle appears at head0.

Source files
------------

// File: rtl/inst_queue_pkg.sv
// Core-wide constants and types shared by the instruction queue.
//   INST_W / PC_W : instruction and PC widths
//   ISSUE_W       : maximum entries pushed or popped per cycle
//   iq_entry_t    : one queue entry {pc, inst}
package inst_queue_pkg;

  localparam int unsigned INST_W  = 32;
  localparam int unsigned PC_W    = 32;
  localparam int unsigned ISSUE_W = 2;

  // Value driven on head outputs when the slot holds no entry.
  localparam logic [PC_W-1:0]   PC_RST   = '0;
  localparam logic [INST_W-1:0] INST_RST = '0;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } iq_entry_t;

  // Clamp a 2-bit pop request to the issue width (a request of 3 is illegal).
  function automatic logic [1:0] issue_sat(input logic [1:0] req);
    return (req > 2'(ISSUE_W)) ? 2'(ISSUE_W) : req;
  endfunction

endpackage

// File: rtl/iq_ram.sv
// Instruction queue storage: DEPTH entries of {pc, inst}.
//   clk            : write clock
//   we0 / we1      : write enables for addr and addr+1
//   waddr          : base write address (second port writes waddr+1, wrapping)
//   wdata0/wdata1  : write payloads
//   raddr          : base read address (second port reads raddr+1, wrapping)
//   rdata0/rdata1  : asynchronous read data
// Storage is intentionally not reset; validity is tracked by the control logic.
module iq_ram
  import inst_queue_pkg::*;
#(
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we0,
  input  logic             we1,
  input  logic [PTR_W-1:0] waddr,
  input  iq_entry_t        wdata0,
  input  iq_entry_t        wdata1,
  input  logic [PTR_W-1:0] raddr,
  output iq_entry_t        rdata0,
  output iq_entry_t        rdata1
);

  iq_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] waddr1;
  logic [PTR_W-1:0] raddr1;

  // DEPTH is a power of two, so PTR_W-bit addition wraps modulo DEPTH.
  assign waddr1 = waddr + PTR_W'(1);
  assign raddr1 = raddr + PTR_W'(1);

  // Dual write; the two addresses always differ since DEPTH >= 4.
  always_ff @(posedge clk) begin
    if (we0) mem[waddr]  <= wdata0;
    if (we1) mem[waddr1] <= wdata1;
  end

  assign rdata0 = mem[raddr];
  assign rdata1 = mem[raddr1];

endmodule

// File: rtl/inst_queue.sv
// Dual-push / dual-pop circular instruction buffer between fetch and ID1.
//   clk, rst                 : clock, synchronous active-high reset
//   flush, exception_flush   : empty the queue (discard same-cycle push/pop)
//   push0/push1 + pc/inst    : fetch slots (push1 only meaningful with push0)
//   pop_cnt                  : entries consumed by issue this cycle (0..2)
//   full, empty, count       : occupancy status
//   head0_* / head1_*        : two oldest entries, zero-latency, masked when absent
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              exception_flush,
  input  logic              push0,
  input  logic              push1,
  input  logic [PC_W-1:0]   push0_pc,
  input  logic [INST_W-1:0] push0_inst,
  input  logic [PC_W-1:0]   push1_pc,
  input  logic [INST_W-1:0] push1_inst,
  input  logic [1:0]        pop_cnt,
  output logic              full,
  output logic              empty,
  output logic              head0_valid,
  output logic [PC_W-1:0]   head0_pc,
  output logic [INST_W-1:0] head0_inst,
  output logic              head1_valid,
  output logic [PC_W-1:0]   head1_pc,
  output logic [INST_W-1:0] head1_inst,
  output logic [PTR_W:0]    count
);

  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr, rd_ptr_next;
  logic [CNT_W-1:0] cnt, cnt_next;

  logic             flush_any;
  logic             full_int;
  logic             push_ok;
  logic             we0, we1;
  logic [1:0]       npush;
  logic [1:0]       pop_req;
  logic [1:0]       npop;
  iq_entry_t        wdata0, wdata1;
  iq_entry_t        rdata0, rdata1;

  assign flush_any = flush | exception_flush;

  // Full uses registered occupancy only: same-cycle pops never admit a push.
  assign full_int = cnt > CNT_W'(DEPTH - 2);

  // A push is all-or-nothing; push1 alone is ignored.
  assign push_ok = push0 & ~full_int & ~flush_any & ~rst;
  assign we0     = push_ok;
  assign we1     = push_ok & push1;
  assign npush   = 2'(we0) + 2'(we1);

  // Pop saturates at current occupancy so cnt never underflows.
  assign pop_req = issue_sat(pop_cnt);
  assign npop    = (CNT_W'(pop_req) > cnt) ? cnt[1:0] : pop_req;

  assign wdata0 = '{pc: push0_pc, inst: push0_inst};
  assign wdata1 = '{pc: push1_pc, inst: push1_inst};

  iq_ram #(.DEPTH(DEPTH)) u_ram (
    .clk    (clk),
    .we0    (we0),
    .we1    (we1),
    .waddr  (wr_ptr),
    .wdata0 (wdata0),
    .wdata1 (wdata1),
    .raddr  (rd_ptr),
    .rdata0 (rdata0),
    .rdata1 (rdata1)
  );

  // Next pointer/occupancy; flush discards any same-cycle push and pop.
  always_comb begin
    wr_ptr_next = wr_ptr;
    rd_ptr_next = rd_ptr;
    cnt_next    = cnt;
    if (flush_any) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      cnt_next    = '0;
    end else begin
      wr_ptr_next = wr_ptr + PTR_W'(npush);
      rd_ptr_next = rd_ptr + PTR_W'(npop);
      cnt_next    = cnt - CNT_W'(npop) + CNT_W'(npush);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      wr_ptr <= wr_ptr_next;
      rd_ptr <= rd_ptr_next;
      cnt    <= cnt_next;
    end
  end

  // Head outputs come straight from registered state; absent slots read as zero.
  assign full        = full_int;
  assign empty       = (cnt == '0);
  assign count       = cnt;
  assign head0_valid = (cnt != '0);
  assign head1_valid = (cnt > CNT_W'(1));
  assign head0_pc    = head0_valid ? rdata0.pc   : PC_RST;
  assign head0_inst  = head0_valid ? rdata0.inst : INST_RST;
  assign head1_pc    = head1_valid ? rdata1.pc   : PC_RST;
  assign head1_inst  = head1_valid ? rdata1.inst : INST_RST;

endmodule

// File: tb/tb_inst_queue.sv
// Directed bench for inst_queue: a vector table plus hand-written
// sequences for fill/full, pointer wrap, flush and reset.
module tb_inst_queue;

  logic        clk = 1'b0;
  logic        rst, flush, exception_flush;
  logic        push0, push1;
  logic [31:0] push0_pc, push0_inst, push1_pc, push1_inst;
  logic [1:0]  pop_cnt;
  logic        full, empty;
  logic        head0_valid, head1_valid;
  logic [31:0] head0_pc, head0_inst, head1_pc, head1_inst;
  logic [4:0]  count;

  int n_checks = 0;
  int n_fails  = 0;
  bit allow_illegal = 1'b0;

  always #5 clk = ~clk;

  inst_queue #(.DEPTH(16)) dut (
    .clk             (clk),
    .rst             (rst),
    .flush           (flush),
    .exception_flush (exception_flush),
    .push0           (push0),
    .push1           (push1),
    .push0_pc        (push0_pc),
    .push0_inst      (push0_inst),
    .push1_pc        (push1_pc),
    .push1_inst      (push1_inst),
    .pop_cnt         (pop_cnt),
    .full            (full),
    .empty           (empty),
    .head0_valid     (head0_valid),
    .head0_pc        (head0_pc),
    .head0_inst      (head0_inst),
    .head1_valid     (head1_valid),
    .head1_pc        (head1_pc),
    .head1_inst      (head1_inst),
    .count           (count)
  );

  typedef struct {
    bit          rst, flush, xflush, push0, push1;
    logic [1:0]  pop;
    logic [31:0] pc0, inst0, pc1, inst1;
    int          e_count;
    bit          e_empty, e_full, e_h0v;
    logic [31:0] e_h0pc, e_h0inst;
    bit          e_h1v;
    logic [31:0] e_h1pc, e_h1inst;
  } vec_t;

  localparam int NVEC = 11;
  vec_t vecs [NVEC];

  function automatic logic [31:0] epc(input int i);
    return 32'h0000_1000 + 32'(4 * i);
  endfunction

  function automatic logic [31:0] einst(input int i);
    return 32'hA000_0000 + 32'(i);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    rst = 1'b0; flush = 1'b0; exception_flush = 1'b0;
    push0 = 1'b0; push1 = 1'b0; pop_cnt = 2'd0;
    push0_pc = '0; push0_inst = '0; push1_pc = '0; push1_inst = '0;
  endtask

  // Clock the current inputs in, move away from the edge, return to idle inputs.
  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic set_push(input bit two, input int a);
    push0 = 1'b1; push0_pc = epc(a); push0_inst = einst(a);
    if (two) begin
      push1 = 1'b1; push1_pc = epc(a + 1); push1_inst = einst(a + 1);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_count"}, 32'(count), 32'd0);
    chk({tag, "_empty"}, 32'(empty), 32'd1);
    chk({tag, "_full"},  32'(full),  32'd0);
    chk({tag, "_h0v"},   32'(head0_valid), 32'd0);
    chk({tag, "_h1v"},   32'(head1_valid), 32'd0);
    chk({tag, "_h0pc"},  head0_pc, 32'd0);
    chk({tag, "_h0inst"}, head0_inst, 32'd0);
    chk({tag, "_h1pc"},  head1_pc, 32'd0);
    chk({tag, "_h1inst"}, head1_inst, 32'd0);
  endtask

  // Fetch protocol monitor: push1 alone and push into a full queue are errors.
  always @(negedge clk) begin
    if (rst === 1'b0 && !allow_illegal) begin
      if (push1 && !push0) begin
        n_fails++;
        $display("FAIL proto_push1_alone: push1=%b push0=%b", push1, push0);
      end
      if (push0 && full === 1'b1 && !flush && !exception_flush) begin
        n_fails++;
        $display("FAIL proto_push_full: push0=%b full=%b", push0, full);
      end
    end
  end

  initial begin
    idle();
    rst = 1'b1;

    //           rst flush xfl p0 p1 pop  pc0            inst0          pc1            inst1          cnt emp ful h0v h0pc           h0inst         h1v h1pc           h1inst
    vecs[0]  = '{1, 0, 0, 0, 0, 2'd0, 32'h0,         32'h0,         32'h0,         32'h0,         0, 1, 0, 0, 32'h0,         32'h0,         0, 32'h0,         32'h0};
    vecs[1]  = '{0, 0, 0, 1, 1, 2'd0, 32'hBFC00000, 32'h24010001, 32'hBFC00004, 32'h24020002, 2, 0, 0, 1, 32'hBFC00000, 32'h24010001, 1, 32'hBFC00004, 32'h24020002};
    vecs[2]  = '{0, 0, 0, 1, 0, 2'd1, 32'hBFC00008, 32'h24030003, 32'h0,         32'h0,         2, 0, 0, 1, 32'hBFC00004, 32'h24020002, 1, 32'hBFC00008, 32'h24030003};
    vecs[3]  = '{0, 0, 0, 0, 0, 2'd2, 32'h0,         32'h0,         32'h0,         32'h0,         0, 1, 0, 0, 32'h0,         32'h0,         0, 32'h0,         32'h0};
    vecs[4]  = '{0, 0, 0, 0, 0, 2'd2, 32'h0,         32'h0,         32'h0,         32'h0,         0, 1, 0, 0, 32'h0,         32'h0,         0, 32'h0,         32'h0};
    vecs[5]  = '{0, 0, 0, 1, 1, 2'd2, 32'h100,       32'h11,        32'h104,       32'h22,        2, 0, 0, 1, 32'h100,       32'h11,        1, 32'h104,       32'h22};
    vecs[6]  = '{0, 0, 0, 0, 0, 2'd1, 32'h0,         32'h0,         32'h0,         32'h0,         1, 0, 0, 1, 32'h104,       32'h22,        0, 32'h0,         32'h0};
    vecs[7]  = '{0, 0, 0, 1, 1, 2'd2, 32'h200,       32'h33,        32'h204,       32'h44,        2, 0, 0, 1, 32'h200,       32'h33,        1, 32'h204,       32'h44};
    vecs[8]  = '{0, 1, 0, 1, 1, 2'd1, 32'h300,       32'h55,        32'h304,       32'h66,        0, 1, 0, 0, 32'h0,         32'h0,         0, 32'h0,         32'h0};
    vecs[9]  = '{0, 0, 0, 1, 0, 2'd0, 32'h400,       32'h77,        32'h0,         32'h0,         1, 0, 0, 1, 32'h400,       32'h77,        0, 32'h0,         32'h0};
    vecs[10] = '{0, 0, 1, 0, 0, 2'd0, 32'h0,         32'h0,         32'h0,         32'h0,         0, 1, 0, 0, 32'h0,         32'h0,         0, 32'h0,         32'h0};

    for (int i = 0; i < NVEC; i++) begin
      rst = vecs[i].rst; flush = vecs[i].flush; exception_flush = vecs[i].xflush;
      push0 = vecs[i].push0; push1 = vecs[i].push1; pop_cnt = vecs[i].pop;
      push0_pc = vecs[i].pc0; push0_inst = vecs[i].inst0;
      push1_pc = vecs[i].pc1; push1_inst = vecs[i].inst1;
      tick();
      chk($sformatf("vec%0d_count", i),  32'(count),       32'(vecs[i].e_count));
      chk($sformatf("vec%0d_empty", i),  32'(empty),       32'(vecs[i].e_empty));
      chk($sformatf("vec%0d_full", i),   32'(full),        32'(vecs[i].e_full));
      chk($sformatf("vec%0d_h0v", i),    32'(head0_valid), 32'(vecs[i].e_h0v));
      chk($sformatf("vec%0d_h0pc", i),   head0_pc,         vecs[i].e_h0pc);
      chk($sformatf("vec%0d_h0inst", i), head0_inst,       vecs[i].e_h0inst);
      chk($sformatf("vec%0d_h1v", i),    32'(head1_valid), 32'(vecs[i].e_h1v));
      chk($sformatf("vec%0d_h1pc", i),   head1_pc,         vecs[i].e_h1pc);
      chk($sformatf("vec%0d_h1inst", i), head1_inst,       vecs[i].e_h1inst);
    end

    // Fill to 15, push while full is dropped, then drain checking order.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      set_push(1'b1, 2 * i);
      tick();
    end
    chk("fill14_count", 32'(count), 32'd14);
    chk("fill14_full",  32'(full),  32'd0);
    set_push(1'b0, 14);
    tick();
    chk("fill15_count", 32'(count), 32'd15);
    chk("fill15_full",  32'(full),  32'd1);
    allow_illegal = 1'b1;
    set_push(1'b1, 90);
    tick();
    allow_illegal = 1'b0;
    chk("pushfull_count", 32'(count), 32'd15);
    chk("pushfull_h0pc",  head0_pc,   epc(0));
    chk("pushfull_h1pc",  head1_pc,   epc(1));
    pop_cnt = 2'd2;
    tick();
    chk("popfull_count", 32'(count), 32'd13);
    chk("popfull_full",  32'(full),  32'd0);
    chk("popfull_h0pc",  head0_pc,   epc(2));
    set_push(1'b0, 15);
    tick();
    chk("refill_count", 32'(count), 32'd14);
    for (int k = 0; k < 6; k++) begin
      pop_cnt = 2'd2;
      tick();
      chk($sformatf("drain%0d_h0pc", k),   head0_pc,   epc(4 + 2 * k));
      chk($sformatf("drain%0d_h0inst", k), head0_inst, einst(4 + 2 * k));
    end
    chk("drain_count", 32'(count), 32'd2);
    chk("drain_h1pc",  head1_pc,   epc(15));

    // Walk both pointers to 15, then a dual push wraps across mem[15]/mem[0].
    do_reset();
    for (int i = 0; i < 15; i++) begin
      set_push(1'b0, 32 + i);
      pop_cnt = 2'd1;
      tick();
      chk($sformatf("walk%0d_count", i), 32'(count), 32'd1);
      chk($sformatf("walk%0d_h0pc", i),  head0_pc,   epc(32 + i));
    end
    pop_cnt = 2'd1;
    tick();
    chk("walk_empty", 32'(empty), 32'd1);
    set_push(1'b1, 100);
    tick();
    chk("wrap_count",  32'(count), 32'd2);
    chk("wrap_h0pc",   head0_pc,   epc(100));
    chk("wrap_h0inst", head0_inst, einst(100));
    chk("wrap_h1pc",   head1_pc,   epc(101));
    chk("wrap_h1inst", head1_inst, einst(101));
    pop_cnt = 2'd1;
    tick();
    chk("wrap_pop_h0pc",  head0_pc,   epc(101));
    chk("wrap_pop_count", 32'(count), 32'd1);

    // Flush and exception flush at cnt=6 discard push and pop.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_push(1'b1, 2 * i);
      tick();
    end
    chk("preflush_count", 32'(count), 32'd6);
    flush = 1'b1; set_push(1'b1, 70); pop_cnt = 2'd1;
    tick();
    chk_cleared("flush");
    for (int i = 0; i < 3; i++) begin
      set_push(1'b1, 2 * i);
      tick();
    end
    chk("prexflush_count", 32'(count), 32'd6);
    exception_flush = 1'b1;
    tick();
    chk_cleared("xflush");
    set_push(1'b0, 50);
    tick();
    chk("postflush_h0pc",  head0_pc,   epc(50));
    chk("postflush_count", 32'(count), 32'd1);

    // Reset with cnt=9 and a push/pop in flight.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_push(1'b1, 2 * i);
      tick();
    end
    set_push(1'b0, 8);
    tick();
    chk("prerst_count", 32'(count), 32'd9);
    rst = 1'b1; set_push(1'b1, 80); pop_cnt = 2'd1;
    tick();
    chk_cleared("rst");
    set_push(1'b0, 60);
    tick();
    chk("postrst_h0v",    32'(head0_valid), 32'd1);
    chk("postrst_h0pc",   head0_pc,         epc(60));
    chk("postrst_h0inst", head0_inst,       einst(60));
    chk("postrst_count",  32'(count),       32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
